load_seq_ctrl: RTL
==================

// Module: load_seq_ctrl
// PURPOSE
// - Sequences one data-memory load per request between the MEM stage and the WB stage.
// - Issues a word-aligned read on a req/ack memory port and selects the byte or halfword lane.
// - Applies sign or zero extension using the WB size encoding, then presents the result with its destination register.
// - Holds pipe_stall while a load is in flight; flags misaligned, reserved-size and timed-out accesses.
// PARAMETERS
// - TIMEOUT   16  cycles to wait for mem_ack before aborting with a bus error (>=2)
// - TO_W       5  width of timeout counter; must hold TIMEOUT
// PORTS
// - clk           in   1   system clock, all logic on rising edge
// - rst_n         in   1   asynchronous active-low reset
// - req_valid     in   1   load request from MEM stage, sampled only in IDLE
// - req_addr      in  32   byte address
// - req_size      in   2   00=word, 01=half, 10=byte, 11=reserved
// - req_unsigned  in   1   1=zero-extend (lhu/lbu), 0=sign-extend; ignored for word
// - req_rd        in   5   destination register
// - flush         in   1   abort current load (branch/exception in flight)
// - mem_req       out  1   memory read strobe, held until mem_ack
// - mem_addr      out  32  {req_addr[31:2],2'b00}, stable while mem_req=1
// - mem_ack       in   1   read data valid this cycle
// - mem_rdata     in  32   read word, little-endian lanes
// - pipe_stall    out  1   1 whenever state != IDLE
// - wb_valid      out  1   one-cycle pulse: wb_data/wb_rd valid
// - wb_data       out 32   extended load result
// - wb_rd         out  5   destination register of wb_data
// - ld_err        out  1   one-cycle pulse: misalign / reserved size / timeout
// - ld_err_code   out  2   01=misalign, 10=reserved size, 11=timeout; held until next error
// BEHAVIOUR
// - Reset: state=IDLE; mem_req, pipe_stall, wb_valid, ld_err = 0; mem_addr, wb_data = 0; wb_rd, ld_err_code = 0.
// - FSM: IDLE -> WAIT -> RESP -> IDLE; IDLE -> ERR -> IDLE.
// - IDLE, req_valid=1, checks pass: latch addr/size/unsigned/rd; next cycle WAIT with mem_req=1.
// - Checks: size 11 -> ERR code 10; half with addr[0]=1, or word with addr[1:0]!=0 -> ERR code 01.
// - Reserved size takes priority over misalign. An ERR load never asserts mem_req.
// - WAIT: mem_req=1 and the timeout counter increments each cycle.
//   - mem_ack=1: capture and extend mem_rdata, go to RESP, drop mem_req.
//   - Counter reaches TIMEOUT-1 without ack: ERR with code 11, drop mem_req.
// - RESP: wb_valid=1 for exactly one cycle, then IDLE; wb_data/wb_rd hold until the next RESP.
// - ERR: ld_err=1 for one cycle, wb_valid stays 0, then IDLE.
// - Latency: req accepted at cycle 0; mem_req from cycle 1; ack at cycle k gives wb_valid at k+1.
//   - Minimum request-to-wb latency is 2 cycles; the next request is accepted the cycle after RESP/ERR.
// - Lane select (little-endian):
//   - byte = rdata[8*a+7:8*a] with a=addr[1:0].
//   - half = rdata[15:0] when addr[1]=0, else rdata[31:16].
//   - Extension is sign (MSB replicated) or zero-fill to 32 bits.
// - Flush:
//   - In WAIT: drop to IDLE next cycle, mem_req drops; a mem_ack arriving the same cycle is discarded; no wb_valid.
//   - In RESP/ERR: the pulse still completes.
//   - In IDLE: a request presented with flush=1 is not accepted.
// - mem_ack outside WAIT is ignored.
// - Asynchronous reset mid-load: immediate IDLE, outputs to reset values; no response generated.
// STRUCTURE
// - Shared package: size encodings (SZ_WORD/SZ_HALF/SZ_BYTE/SZ_RSVD), FSM state encodings, error codes.
// - Sub-module: load_extend (combinational lane select + sign/zero extend: rdata, addr[1:0], size, unsigned -> data).
// - The FSM, timeout counter and request latches stay in load_seq_ctrl.
// TESTING
// - lb addr=0x103, unsigned=0, ack after 3 cycles with rdata=0x80112233 -> wb_data=0xFFFFFF80, wb_valid 4 cycles after mem_req.
// - lhu addr=0x102, rdata=0x9ABC1234 -> wb_data=0x00009ABC; lh same -> 0xFFFF9ABC; lw addr=0x100 -> 0x9ABC1234.
// - lw addr=0x102 -> ld_err pulse, ld_err_code=01, mem_req never asserts. size=11 at addr 0x101 -> code 10.
// - No ack, TIMEOUT=16 -> mem_req high 16 cycles, then ld_err code 11, pipe_stall falls.
// - flush in 2nd WAIT cycle with simultaneous mem_ack -> no wb_valid, IDLE next cycle; a new request is accepted right after.
// - rst_n low in WAIT -> mem_req/pipe_stall 0 immediately; after release a new lb completes normally.

Source files
------------

// File: rtl/load_seq_ctrl_pkg.sv
// Shared encodings for the load sequencer: access sizes, FSM states and error codes.
package load_seq_ctrl_pkg;

  // Access size encoding as delivered by the MEM stage.
  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  // Error codes reported on ld_err_code_o.
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_RSVD     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp,
    StErr
  } state_e;

  // Halfwords need an even address and words need a 4-byte-aligned address.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    return ((size == SZ_HALF) && addr_lo[0]) || ((size == SZ_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/load_seq_ctrl_extend.sv
// Combinational lane select and sign/zero extension of a little-endian read word.
module load_seq_ctrl_extend
  import load_seq_ctrl_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte/halfword lane, then extend it to 32 bits.
  always_comb begin
    byte_sel = rdata_i[7:0];
    unique case (addr_lo_i)
      2'b00: byte_sel = rdata_i[7:0];
      2'b01: byte_sel = rdata_i[15:8];
      2'b10: byte_sel = rdata_i[23:16];
      2'b11: byte_sel = rdata_i[31:24];
      default: byte_sel = rdata_i[7:0];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    data_o = rdata_i;
    unique case (size_i)
      SZ_HALF: data_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
      SZ_BYTE: data_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/load_seq_ctrl.sv
// Sequences one data-memory load per request from MEM to WB over a req/ack port.
module load_seq_ctrl
  import load_seq_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned TO_W    = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  input  logic [31:0] req_addr_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [4:0]  req_rd_i,
  input  logic        flush_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        pipe_stall_o,
  output logic        wb_valid_o,
  output logic [31:0] wb_data_o,
  output logic [4:0]  wb_rd_o,
  output logic        ld_err_o,
  output logic [1:0]  ld_err_code_o
);

  localparam logic [TO_W-1:0] ToLast = TO_W'(TIMEOUT - 1);

  state_e          state_q;
  logic            mem_req_q;
  logic [31:0]     mem_addr_q;
  logic [1:0]      addr_lo_q;
  logic [1:0]      size_q;
  logic            unsigned_q;
  logic [4:0]      rd_q;
  logic [TO_W-1:0] to_cnt_q;
  logic            wb_valid_q;
  logic [31:0]     wb_data_q;
  logic [4:0]      wb_rd_q;
  logic            ld_err_q;
  logic [1:0]      err_code_q;
  logic [31:0]     ext_data;

  load_seq_ctrl_extend u_extend (
    .rdata_i    (mem_rdata_i),
    .addr_lo_i  (addr_lo_q),
    .size_i     (size_q),
    .unsigned_i (unsigned_q),
    .data_o     (ext_data)
  );

  // Load FSM with request latches, timeout counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      addr_lo_q  <= '0;
      size_q     <= SZ_WORD;
      unsigned_q <= 1'b0;
      rd_q       <= '0;
      to_cnt_q   <= '0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
      ld_err_q   <= 1'b0;
      err_code_q <= '0;
    end else begin
      wb_valid_q <= 1'b0;
      ld_err_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // A request arriving together with a flush belongs to a squashed instruction.
          if (req_valid_i && !flush_i) begin
            if (req_size_i == SZ_RSVD) begin
              state_q    <= StErr;
              ld_err_q   <= 1'b1;
              err_code_q <= ERR_RSVD;
            end else if (is_misaligned(req_size_i, req_addr_i[1:0])) begin
              state_q    <= StErr;
              ld_err_q   <= 1'b1;
              err_code_q <= ERR_MISALIGN;
            end else begin
              state_q    <= StWait;
              mem_req_q  <= 1'b1;
              mem_addr_q <= {req_addr_i[31:2], 2'b00};
              addr_lo_q  <= req_addr_i[1:0];
              size_q     <= req_size_i;
              unsigned_q <= req_unsigned_i;
              rd_q       <= req_rd_i;
              to_cnt_q   <= '0;
            end
          end
        end
        StWait: begin
          // Flush beats a same-cycle ack; the returned data is dropped.
          if (flush_i) begin
            state_q   <= StIdle;
            mem_req_q <= 1'b0;
          end else if (mem_ack_i) begin
            state_q    <= StResp;
            mem_req_q  <= 1'b0;
            wb_valid_q <= 1'b1;
            wb_data_q  <= ext_data;
            wb_rd_q    <= rd_q;
          end else if (to_cnt_q == ToLast) begin
            state_q    <= StErr;
            mem_req_q  <= 1'b0;
            ld_err_q   <= 1'b1;
            err_code_q <= ERR_TIMEOUT;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        StResp:  state_q <= StIdle;
        StErr:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mem_req_o     = mem_req_q;
  assign mem_addr_o    = mem_addr_q;
  assign pipe_stall_o  = (state_q != StIdle);
  assign wb_valid_o    = wb_valid_q;
  assign wb_data_o     = wb_data_q;
  assign wb_rd_o       = wb_rd_q;
  assign ld_err_o      = ld_err_q;
  assign ld_err_code_o = err_code_q;

endmodule
